// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// The result register only updates at the end of a conversion, so the digit decoders never see partial values.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int W     = BCD_W + BIN_W;
  localparam int CW    = $clog2(BIN_W + 1);

  if (BIN_W < 4 || BIN_W > 20) begin : g_bad_w
    $error("bin_to_bcd_seq: BIN_W must be in 4..20");
  end
  if ((64'd10 ** DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       work_q, work_d, adj;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d, done_q, done_d;

  // All nibbles are corrected in parallel from their pre-adjust values.
  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[BIN_W+4*i +: 4] >= 4'd5)
        adj[BIN_W+4*i +: 4] = work_q[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {{BCD_W{1'b0}}, bin_in};
          cnt_d   = CW'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = {adj[W-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = work_q[W-1 -: BCD_W];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flags are registered alongside the state so they come straight from flops.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: timeline model of the handshake plus a decimal reference,
// checked every cycle, with directed and randomized conversions.
module tb_bin_to_bcd_seq;
  localparam int BIN_W  = 10;
  localparam int DIGITS = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy, done;
  logic [15:0]      bcd_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b1;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: k counts edges since the accepting edge; busy for k=0..BIN_W,
  // done at k=BIN_W, result appears on the edge that makes k=BIN_W+1.
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_val = 0;
  logic [15:0] m_bcd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_k      = 0;
      m_bcd    = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_val    = int'(bin_in);
      end
    end else begin
      m_k++;
      if (m_k == BIN_W + 1) begin
        m_bcd    = to_bcd(m_val);
        m_active = 1'b0;
      end
    end
    #1;
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(m_active));
      cmp("done", 32'(done), 32'(m_active && m_k == BIN_W));
      cmp("bcd_out", 32'(bcd_out), 32'(m_bcd));
      for (int i = 0; i < DIGITS; i++)
        if (bcd_out[4*i +: 4] > 4'd9) cmp("nibble_le9", 32'(bcd_out[4*i +: 4]), 32'd9);
    end
  end

  // Launches v (unless already launched by a chained call), waits for done
  // with a bound, then returns bcd_out after the update edge.
  task automatic run(input int v, input bit noise, input bit skip_launch,
                     input bit chain, input int nxt, output logic [15:0] res);
    int n;
    bit seen;
    logic [15:0] pre;
    if (!skip_launch) @(negedge clk);
    pre    = bcd_out;
    start  = 1'b1;
    bin_in = BIN_W'(v);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      cmp("hold", 32'(bcd_out), 32'(pre));
      if (done) seen = 1'b1;
      start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bin_in = BIN_W'($urandom);
    end
    if (chain) begin
      start  = 1'b1;
      bin_in = BIN_W'(nxt);
    end else begin
      start = 1'b0;
    end
    cmp("latency", 32'(n), 32'(BIN_W + 1));
    @(negedge clk);
    res = bcd_out;
  endtask

  logic [15:0] res;

  initial begin
    cmp("model_0", 32'(to_bcd(0)), 32'h0000);
    cmp("model_255", 32'(to_bcd(255)), 32'h0255);
    cmp("model_1023", 32'(to_bcd(1023)), 32'h1023);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start  = 1'($urandom_range(0, 1));
      bin_in = BIN_W'($urandom);
    end
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_bcd", 32'(bcd_out), 32'h0000);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    cmp("idle_bcd", 32'(bcd_out), 32'h0000);

    run(0, 1'b0, 1'b0, 1'b0, 0, res);    cmp("conv_0", 32'(res), 32'h0000);
    run(255, 1'b0, 1'b0, 1'b0, 0, res);  cmp("conv_255", 32'(res), 32'h0255);
    run(1023, 1'b0, 1'b0, 1'b0, 0, res); cmp("conv_1023", 32'(res), 32'h1023);

    // Restart pulses with other operands during the conversion must be ignored.
    run(999, 1'b0, 1'b0, 1'b0, 0, res);  cmp("conv_999", 32'(res), 32'h0999);
    run(512, 1'b1, 1'b0, 1'b0, 0, res);  cmp("conv_512_noisy", 32'(res), 32'h0512);
    repeat (3) begin
      @(negedge clk);
      cmp("no_second_done", 32'(done), 32'd0);
    end

    // Back-to-back: start held in the cycle right after done.
    run(333, 1'b0, 1'b0, 1'b1, 100, res); cmp("conv_333", 32'(res), 32'h0333);
    run(100, 1'b0, 1'b1, 1'b0, 0, res);   cmp("conv_100_b2b", 32'(res), 32'h0100);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(777);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("midrst_busy", 32'(busy), 32'd0);
    cmp("midrst_done", 32'(done), 32'd0);
    cmp("midrst_bcd", 32'(bcd_out), 32'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (BIN_W + 3) begin
      @(negedge clk);
      cmp("midrst_no_done", 32'(done), 32'd0);
    end
    run(42, 1'b0, 1'b0, 1'b0, 0, res);   cmp("conv_42", 32'(res), 32'h0042);

    for (int v = 0; v < (1 << BIN_W); v++) begin
      run(v, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, res);
      cmp("exhaustive", 32'(res), 32'(to_bcd(v)));
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). Sits directly upstream of the per-digit BCD-to-seven-segment decoders.
- Takes an unsigned binary value under a start/done handshake and produces DIGITS packed BCD nibbles. Each nibble drives one decoder's 4-bit bcd input.
- Output is registered and held stable between conversions, so the decoders see no intermediate values.

Parameters:
- BIN_W, 10, width of binary input in bits. Legal range 4..20.
- DIGITS, 4, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1. Elaboration error otherwise.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned binary operand; captured on the accepted start edge only.
- busy  output  1  high while a conversion is in progress (states SHIFT and DONE).
- done  output  1  single-cycle pulse: bcd_out has just been updated.
- bcd_out  output  4*DIGITS  packed BCD result. Bits [3:0] are units, [7:4] are tens, and so on. Each nibble is 0..9.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, internal shift register and counter cleared. Takes effect immediately, including mid-conversion. Any in-flight conversion is discarded and no done is issued.
- Internal registers:
  - working register of width 4*DIGITS+BIN_W: BCD field above the binary field.
  - shift counter: width ceil(log2(BIN_W+1)).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at a clock edge: load BCD field=0, binary field=bin_in, counter=BIN_W, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT (one iteration per cycle):
  - First, each BCD nibble of the working register that is >=5 gets +3. All nibbles are evaluated in parallel on pre-adjust values.
  - Then the whole working register shifts left by 1, with 0 into the LSB.
  - Counter decrements. When the counter reaches 1 at the edge (the BIN_W-th shift), go to DONE.
- DONE (one cycle): bcd_out <= final BCD field, done=1 for exactly this cycle, busy=1; next state IDLE.
- Latency: if start is accepted at edge E0, done is high in the cycle after edge E0+BIN_W. bcd_out changes at edge E0+BIN_W+1. For BIN_W=10, done is high 11 cycles after the accepting edge.
- Throughput: a new start is accepted once the block is back in IDLE, i.e. the cycle after done. The maximum conversion rate is one per BIN_W+2 cycles.
- start while busy=1 (SHIFT or DONE) is ignored. It is not queued, and bin_in changes are ignored.
- bcd_out holds the previous result throughout a conversion; it changes only in DONE. No intermediate value is visible.
- Leading digits are zero, not blanked; blanking is the display stage's concern.
- bin_in = 0: result all-zero nibbles, with normal latency and done pulse.
- bin_in = 2^BIN_W-1: result is its exact decimal value. No nibble ever exceeds 9.
- done and busy are registered outputs; there is no combinational path from inputs to outputs.

Test Plan:
- Reset values: hold rst_n=0 with random inputs -> busy=0, done=0, bcd_out=16'h0000. Release reset, idle 5 cycles -> outputs unchanged.
- Basic conversions (BIN_W=10, DIGITS=4):
  - bin_in=0 -> bcd_out=16'h0000.
  - bin_in=255 -> 16'h0255.
  - bin_in=1023 -> 16'h1023.
  - For each: done high exactly one cycle, 11 cycles after the accepting edge; busy high for 11 cycles.
- Hold and ignore: after converting 999 (16'h0999), start 512 and re-pulse start with bin_in=7 during SHIFT -> bcd_out stays 16'h0999 until done, then becomes 16'h0512. No second done follows.
- Back-to-back: assert start in the cycle after done with bin_in=100 -> accepted; next done yields 16'h0100.
- Reset mid-operation: start 777, drop rst_n asynchronously at shift 5 -> immediate busy=0, bcd_out=0, and done never pulses. Then start 42 -> 16'h0042 with normal latency.
- Exhaustive: all 1024 inputs converted sequentially and checked against a reference decimal model -> every result matches and every nibble is <=9.
